// File: rtl/score_overlay.sv
// score_overlay: last pixel stage of the wall/collision block.
//  - Once per frame (at the start of vertical blank) the 16-bit score is
//    snapshotted and converted to 5 BCD digits by a double-dabble FSM.
//  - The last converted value is drawn as up to 5 scaled 8x8 glyphs with
//    leading-zero blanking, then mixed with the ball/wall/flash layers.
// Ports:
//  clk75MHz, nReset      : pixel clock, async active-low reset
//  PixX, PixY            : current pixel position (stage 0)
//  Wall, Ball, Kollision : layer flags, one cycle behind PixX/PixY
//  Punkte                : score, unsigned binary
//  Red, Green, Blue      : 4-bit colour channels, 2 cycles after PixX/PixY
//  BcdOut, BcdValid      : last converted score (MS digit in [19:16]) and
//                          a one-cycle pulse when it updates
// Optional feature: define SCORE_OVERLAY_FLASH_EN to flash the background
// red for FLASH_FRAMES frames after a collision.
module score_overlay #(
  parameter logic [10:0] SCORE_X      = 11'd16,
  parameter logic [9:0]  SCORE_Y      = 10'd16,
  parameter int          SCALE_LOG2   = 2,
  parameter int          H_VISIBLE    = 1024,
  parameter int          V_VISIBLE    = 768,
  parameter int          FLASH_FRAMES = 30
) (
  input  logic        clk75MHz,
  input  logic        nReset,
  input  logic [10:0] PixX,
  input  logic [9:0]  PixY,
  input  logic        Wall,
  input  logic        Ball,
  input  logic        Kollision,
  input  logic [15:0] Punkte,
  output logic [3:0]  Red,
  output logic [3:0]  Green,
  output logic [3:0]  Blue,
  output logic [19:0] BcdOut,
  output logic        BcdValid
);

  localparam int          GLYPH   = 8 << SCALE_LOG2;
  localparam logic [10:0] FIELD_W = 11'(5 * GLYPH);
  localparam logic [9:0]  FIELD_H = 10'(GLYPH);
  localparam logic [10:0] H_VIS   = 11'(H_VISIBLE);
  localparam logic [9:0]  V_VIS   = 10'(V_VISIBLE);

  localparam logic [11:0] RGB_BLANK = 12'h000;
  localparam logic [11:0] RGB_SCORE = 12'hFFF;
  localparam logic [11:0] RGB_BALL  = 12'hFF0;
  localparam logic [11:0] RGB_WALL  = 12'h00F;
  localparam logic [11:0] RGB_FLASH = 12'hF00;
  localparam logic [11:0] RGB_BG    = 12'h112;

  // start of vertical blank: one snapshot per frame
  logic trigger;
  assign trigger = (PixX == 11'd0) && (PixY == V_VIS);

  // ---------------------------------------------------------------------
  // Double-dabble converter
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t           state_q, state_d;
  logic [15:0]      bin_q, bin_d;
  logic [4:0][3:0]  bcd_q, bcd_d, bcd_adj;
  logic [3:0]       iter_q, iter_d;
  logic [4:0][3:0]  bcd_out_q, bcd_out_d;
  logic             bcd_valid_q, bcd_valid_d;

  for (genvar g = 0; g < 5; g++) begin : g_adj
    assign bcd_adj[g] = (bcd_q[g] >= 4'd5) ? bcd_q[g] + 4'd3 : bcd_q[g];
  end

  always_ff @(posedge clk75MHz or negedge nReset) begin
    if (!nReset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (trigger) state_d = CONV;
      CONV:    if (iter_q == 4'd15) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    iter_d      = iter_q;
    bcd_out_d   = bcd_out_q;
    bcd_valid_d = 1'b0;
    case (state_q)
      IDLE: if (trigger) begin
        bin_d  = Punkte;
        bcd_d  = '0;
        iter_d = '0;
      end
      CONV: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        iter_d         = iter_q + 4'd1;
      end
      DONE: begin
        bcd_out_d   = bcd_q;
        bcd_valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk75MHz or negedge nReset) begin
    if (!nReset) begin
      bin_q       <= '0;
      bcd_q       <= '0;
      iter_q      <= '0;
      bcd_out_q   <= '0;
      bcd_valid_q <= 1'b0;
    end else begin
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      iter_q      <= iter_d;
      bcd_out_q   <= bcd_out_d;
      bcd_valid_q <= bcd_valid_d;
    end
  end

  assign BcdOut   = bcd_out_q;
  assign BcdValid = bcd_valid_q;

  // ---------------------------------------------------------------------
  // Glyph addressing (stage 0 -> 1)
  // ---------------------------------------------------------------------
  // Pixels left of / above the field wrap to large values and fail the
  // range check, so a single unsigned compare covers both sides.
  logic [10:0] rel_x;
  logic [9:0]  rel_y;
  logic        in_field;
  logic [2:0]  dig_idx, col, row;

  assign rel_x    = PixX - SCORE_X;
  assign rel_y    = PixY - SCORE_Y;
  assign in_field = (rel_x < FIELD_W) && (rel_y < FIELD_H);
  assign dig_idx  = rel_x[3+SCALE_LOG2 +: 3];
  assign col      = rel_x[SCALE_LOG2 +: 3];
  assign row      = rel_y[SCALE_LOG2 +: 3];

  // lz[i]: display digit i (0 = MS) and everything left of it are zero.
  // Digit 4 is never blanked, so it needs no entry.
  logic [3:0] lz;
  for (genvar i = 0; i < 4; i++) begin : g_lz
    if (i == 0) begin : g_first
      assign lz[i] = (bcd_out_q[4] == 4'd0);
    end else begin : g_rest
      assign lz[i] = lz[i-1] && (bcd_out_q[4-i] == 4'd0);
    end
  end

  // Bit 7 of each row is the leftmost column; codes 10..15 draw nothing.
  function automatic logic [7:0] font_row(input logic [3:0] d, input logic [2:0] r);
    logic [63:0] g;
    case (d)
      4'd0:    g = 64'hFFC3_C3C3_C3C3_C3FF;
      4'd1:    g = 64'h1838_1818_1818_187E;
      4'd2:    g = 64'hFF03_03FF_C0C0_C0FF;
      4'd3:    g = 64'hFF03_037F_0303_03FF;
      4'd4:    g = 64'hC3C3_C3FF_0303_0303;
      4'd5:    g = 64'hFFC0_C0FF_0303_03FF;
      4'd6:    g = 64'hFFC0_C0FF_C3C3_C3FF;
      4'd7:    g = 64'hFF03_060C_1818_1818;
      4'd8:    g = 64'hFFC3_C3FF_C3C3_C3FF;
      4'd9:    g = 64'hFFC3_C3FF_0303_03FF;
      default: g = 64'h0;
    endcase
    return g[{3'd7 - r, 3'b000} +: 8];
  endfunction

  logic [3:0] nib;
  logic       dig_blank;
  logic [7:0] font_bits;

  always_comb begin
    nib       = 4'hF;
    dig_blank = 1'b1;
    case (dig_idx)
      3'd0: begin nib = bcd_out_q[4]; dig_blank = lz[0]; end
      3'd1: begin nib = bcd_out_q[3]; dig_blank = lz[1]; end
      3'd2: begin nib = bcd_out_q[2]; dig_blank = lz[2]; end
      3'd3: begin nib = bcd_out_q[1]; dig_blank = lz[3]; end
      3'd4: begin nib = bcd_out_q[0]; dig_blank = 1'b0;  end
      default: ;
    endcase
  end

  assign font_bits = font_row(nib, row);

  logic score_pix_q, score_pix_d;
  logic blank_q, blank_d;

  assign score_pix_d = in_field && !dig_blank && font_bits[3'd7 - col];
  assign blank_d     = (PixX >= H_VIS) || (PixY >= V_VIS);

  always_ff @(posedge clk75MHz or negedge nReset) begin
    if (!nReset) begin
      score_pix_q <= 1'b0;
      blank_q     <= 1'b0;
    end else begin
      score_pix_q <= score_pix_d;
      blank_q     <= blank_d;
    end
  end

  // ---------------------------------------------------------------------
  // Collision flash
  // ---------------------------------------------------------------------
  logic flash_on;

`ifdef SCORE_OVERLAY_FLASH_EN
  localparam int FW = (FLASH_FRAMES < 2) ? 1 : $clog2(FLASH_FRAMES + 1);

  logic [FW-1:0] flash_q, flash_d;

  // a collision reload wins over the per-frame decrement
  always_comb begin
    flash_d = flash_q;
    if (trigger && (flash_q != '0)) flash_d = flash_q - FW'(1);
    if (Kollision)                  flash_d = FW'(FLASH_FRAMES);
  end

  always_ff @(posedge clk75MHz or negedge nReset) begin
    if (!nReset) flash_q <= '0;
    else         flash_q <= flash_d;
  end

  assign flash_on = (flash_q != '0);
`else
  logic unused_kollision;
  assign unused_kollision = Kollision;
  assign flash_on         = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Layer mix (stage 1 -> 2)
  // ---------------------------------------------------------------------
  logic [11:0] rgb_q, rgb_d;

  always_comb begin
    rgb_d = RGB_BG;
    if      (blank_q)     rgb_d = RGB_BLANK;
    else if (score_pix_q) rgb_d = RGB_SCORE;
    else if (Ball)        rgb_d = RGB_BALL;
    else if (Wall)        rgb_d = RGB_WALL;
    else if (flash_on)    rgb_d = RGB_FLASH;
  end

  always_ff @(posedge clk75MHz or negedge nReset) begin
    if (!nReset) rgb_q <= '0;
    else         rgb_q <= rgb_d;
  end

  assign Red   = rgb_q[11:8];
  assign Green = rgb_q[7:4];
  assign Blue  = rgb_q[3:0];

endmodule
